drm_burst_reader: RTL and testbench

Read-side DMA master for the DRM unit. It fetches an integer number of 81-beat groups from external memory over a simplified AXI4 read channel and emits a 256-bit valid-only beat stream. That stream drives the DRM width converter (256→324 bit, 81 in / 64 out) directly. The converter has no back-pressure, so this block guarantees that every job delivers exactly `num_groups × GROUP_BEATS` beats in order, with no duplicates or drops.

---
 rtl/drm_burst_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_drm_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_burst_reader.sv
// Read-side DMA master for the DRM unit: fetches num_groups x GROUP_BEATS beats over a
// simplified AXI4 read channel, one burst at a time, and forwards them as a valid-only stream.
module drm_burst_reader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256,
  parameter int MAX_BURST   = 16,
  parameter int GROUP_BEATS = 81,
  parameter int GRP_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [GRP_WIDTH-1:0]  num_groups,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int CNT_W     = GRP_WIDTH + 7;
  localparam int BLEN_W    = $clog2(MAX_BURST) + 1;
  localparam int BEAT_LSB  = $clog2(DATA_WIDTH / 8);
  localparam int ALIGN_LSB = $clog2(MAX_BURST) + BEAT_LSB;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_LSB) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Beats in the next burst: whatever is left, capped at MAX_BURST.
  function automatic logic [BLEN_W-1:0] burst_beats(input logic [CNT_W-1:0] rem);
    logic [BLEN_W-1:0] n;
    if (rem >= CNT_W'(MAX_BURST)) begin
      n = BLEN_W'(MAX_BURST);
    end else begin
      n = rem[BLEN_W-1:0];
    end
    return n;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [BLEN_W-1:0]     blen_q, blen_d;
  logic [BLEN_W-1:0]     bcnt_q, bcnt_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  logic [CNT_W-1:0]      total_s;
  logic [CNT_W-1:0]      rem_dec_s;
  logic [BLEN_W-1:0]     blen_start_s;
  logic [BLEN_W-1:0]     blen_next_s;
  logic [ADDR_WIDTH-1:0] addr_step_s;
  logic                  beat_s;
  logic                  last_in_burst_s;

  assign total_s         = CNT_W'(num_groups) * CNT_W'(GROUP_BEATS);
  assign rem_dec_s       = rem_q - CNT_W'(1);
  assign blen_start_s    = burst_beats(total_s);
  assign blen_next_s     = burst_beats(rem_dec_s);
  assign addr_step_s     = ADDR_WIDTH'(blen_q) << BEAT_LSB;
  assign beat_s          = rready_q & rvalid;
  assign last_in_burst_s = (bcnt_q == BLEN_W'(1));

  // Next-state and registered-output logic for the job FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    blen_d      = blen_q;
    bcnt_d      = bcnt_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    err_d       = err_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    valid_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          addr_d = base_addr & ALIGN_MASK;
          rem_d  = total_s;
          if (total_s != '0) begin
            blen_d  = blen_start_s;
            arlen_d = 8'(blen_start_s - BLEN_W'(1));
            state_d = S_ADDR;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          bcnt_d    = blen_q;
          state_d   = S_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      S_DATA: begin
        if (beat_s) begin
          valid_out_d = 1'b1;
          data_out_d  = rdata;
          rem_d       = rem_dec_s;
          bcnt_d      = bcnt_q - BLEN_W'(1);
          // A bad response is flagged but the beat still goes out to keep the converter aligned.
          if ((rresp != 2'b00) || (rlast != last_in_burst_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (last_in_burst_s) begin
            rready_d = 1'b0;
            if (rem_dec_s == '0) begin
              state_d = S_FIN;
            end else begin
              addr_d  = addr_q + addr_step_s;
              blen_d  = blen_next_s;
              arlen_d = 8'(blen_next_s - BLEN_W'(1));
              state_d = S_ADDR;
            end
          end else begin
            rready_d = 1'b1;
          end
        end else begin
          valid_out_d = 1'b0;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any job immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      blen_q      <= '0;
      bcnt_q      <= '0;
      arlen_q     <= 8'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      blen_q      <= blen_d;
      bcnt_q      <= bcnt_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign araddr    = addr_q;
  assign arlen     = arlen_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_drm_burst_reader.sv
// Scoreboard bench for drm_burst_reader: an AXI read-slave model with a synthetic memory,
// expected AR/beat queues filled at job issue and drained by monitor processes.
module tb_drm_burst_reader;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [GW-1:0] num_groups;
  logic          busy, done, err;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] data_out;
  logic          valid_out;

  drm_burst_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_groups(num_groups),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_q[$];
  logic [39:0]   exp_ar_q[$];

  int          beats_seen, done_seen, ar_count;
  logic [31:0] first_ar_addr;
  logic [7:0]  last_ar_len;
  int          max_ar_delay, max_gap, rresp_err_beat, rlast_err_beat, slave_beat;
  logic        done_needs_prev_valid;
  logic        prev_v;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return w;
  endfunction

  task automatic push_expect(input logic [31:0] al, input int t);
    int rem, len;
    logic [31:0] a;
    rem = t;
    a   = al;
    while (rem > 0) begin
      len = (rem > 16) ? 16 : rem;
      exp_ar_q.push_back({8'(len - 1), a});
      a   = a + 32'(len) * 32'd32;
      rem = rem - len;
    end
    for (int i = 0; i < t; i++) exp_q.push_back(mem_word(al + 32'(i) * 32'd32));
  endtask

  // Beat monitor: pops the scoreboard whenever the DUT presents a beat.
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL beat_unexpected: got beat %0h, required no beat", data_out);
        end else begin
          check("beat_data", data_out, exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (done_needs_prev_valid) check("done_after_last_beat", DW'(prev_v), DW'(1'b1));
      end
      prev_v = valid_out;
    end
  end

  // AXI read-slave model; also checks each accepted AR against the expected queue.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [39:0] e;
    int d, g, w;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rstn && arvalid) begin
        a = araddr;
        l = arlen;
        d = $urandom_range(max_ar_delay, 0);
        repeat (d) begin @(posedge clk); #1; end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        if (rstn) begin
          ar_count++;
          if (ar_count == 1) first_ar_addr = a;
          last_ar_len = l;
          if (exp_ar_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ar_unexpected: got addr %0h len %0d, required no request", a, l);
          end else begin
            e = exp_ar_q.pop_front();
            check("ar_addr", DW'(a), DW'(e[31:0]));
            check("ar_len", DW'(l), DW'(e[39:32]));
          end
        end
        for (int b = 0; b <= int'(l) && rstn; b++) begin
          g = $urandom_range(max_gap, 0);
          rvalid = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
          rvalid = 1'b1;
          rdata  = mem_word(a + 32'(b) * 32'd32);
          rresp  = (slave_beat == rresp_err_beat) ? 2'd2 : 2'd0;
          rlast  = (b == int'(l)) || (slave_beat == rlast_err_beat);
          w = 0;
          while (!rready && rstn && w < 50) begin @(posedge clk); #1; w++; end
          if (w >= 50) begin
            tests++;
            fails++;
            $display("FAIL rready_timeout: got rready 0 for 50 cycles, required 1");
          end
          @(posedge clk); #1;
          slave_beat++;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input int ng, input int ard, input int gap,
                         input logic exp_err, input int rr_beat, input int rl_beat,
                         input logic busy_start);
    int t, cyc;
    t = ng * 81;
    max_ar_delay = ard; max_gap = gap;
    rresp_err_beat = rr_beat; rlast_err_beat = rl_beat;
    slave_beat = 0; ar_count = 0; beats_seen = 0; done_seen = 0;
    done_needs_prev_valid = (t > 0);
    push_expect(base & 32'hFFFF_FE00, t);
    base_addr = base; num_groups = GW'(ng); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", DW'(busy), DW'(1'b1));
    check("err_cleared_on_start", DW'(err), DW'(1'b0));
    cyc = 0;
    while (!done && cyc < 5000) begin
      start = busy_start && (cyc == 30);
      if (busy_start && cyc == 30) begin num_groups = 16'd5; base_addr = 32'h0; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 5000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in 5000 cycles, required done");
    end
    check("err_at_done", DW'(err), DW'(exp_err));
    check("busy_fall", DW'(busy), DW'(1'b0));
    @(posedge clk); #1;
    check("done_one_cycle", DW'(done), DW'(1'b0));
    check("beat_count", DW'(beats_seen), DW'(t));
    check("done_count", DW'(done_seen), DW'(1));
    check("beat_q_drained", DW'(exp_q.size()), DW'(0));
    check("ar_q_drained", DW'(exp_ar_q.size()), DW'(0));
  endtask

  initial begin
    int w;
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_groups = '0;
    max_ar_delay = 0; max_gap = 0; rresp_err_beat = -1; rlast_err_beat = -1;
    slave_beat = 0; ar_count = 0; beats_seen = 0; done_seen = 0;
    done_needs_prev_valid = 1'b0; first_ar_addr = '0; last_ar_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), DW'(1'b0));
    check("rst_done", DW'(done), DW'(1'b0));
    check("rst_err", DW'(err), DW'(1'b0));
    check("rst_araddr", DW'(araddr), DW'(32'h0));
    check("rst_arlen", DW'(arlen), DW'(8'h0));
    check("rst_arvalid", DW'(arvalid), DW'(1'b0));
    check("rst_rready", DW'(rready), DW'(1'b0));
    check("rst_data_out", data_out, {DW{1'b0}});
    check("rst_valid_out", DW'(valid_out), DW'(1'b0));
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic job: 81 beats -> bursts of 16 x5 and 1.
    run_job(32'h1000, 1, 0, 0, 1'b0, -1, -1, 1'b0);
    check("basic_ar_count", DW'(ar_count), DW'(6));
    check("basic_first_araddr", DW'(first_ar_addr), DW'(32'h1000));
    check("basic_last_arlen", DW'(last_ar_len), DW'(8'd0));

    // Three groups with random arready delay and rvalid gaps: 243 = 15*16 + 3.
    run_job(32'h2000, 3, 5, 3, 1'b0, -1, -1, 1'b0);
    check("multi_beats", DW'(beats_seen), DW'(243));
    check("multi_ar_count", DW'(ar_count), DW'(16));
    check("multi_last_arlen", DW'(last_ar_len), DW'(8'd2));

    // Misaligned base is rounded down to 512 bytes.
    run_job(32'h1234, 1, 1, 1, 1'b0, -1, -1, 1'b0);
    check("misaligned_first_araddr", DW'(first_ar_addr), DW'(32'h1200));

    // Zero-length job: done two cycles after start, no AR.
    ar_count = 0; done_seen = 0; done_needs_prev_valid = 1'b0;
    base_addr = 32'h3000; num_groups = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_busy", DW'(busy), DW'(1'b1));
    check("zero_done_early", DW'(done), DW'(1'b0));
    @(posedge clk); #1;
    check("zero_done", DW'(done), DW'(1'b1));
    check("zero_busy_fall", DW'(busy), DW'(1'b0));
    @(posedge clk); #1;
    check("zero_done_pulse", DW'(done), DW'(1'b0));
    repeat (3) @(posedge clk);
    #1;
    check("zero_ar_count", DW'(ar_count), DW'(0));
    check("zero_done_count", DW'(done_seen), DW'(1));

    // rresp error on beat 20: sticky err, all beats delivered, next start clears it.
    run_job(32'h4000, 1, 1, 1, 1'b1, 20, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("err_sticky", DW'(err), DW'(1'b1));
    run_job(32'h4000, 1, 0, 0, 1'b0, -1, -1, 1'b0);

    // Early rlast at beat 5 of the first burst.
    run_job(32'h5000, 1, 0, 0, 1'b1, -1, 4, 1'b0);

    // start while busy is ignored.
    run_job(32'h6000, 1, 2, 2, 1'b0, -1, -1, 1'b1);

    // Reset mid-DATA.
    max_ar_delay = 0; max_gap = 0; rresp_err_beat = -1; rlast_err_beat = -1;
    slave_beat = 0; ar_count = 0; beats_seen = 0; done_needs_prev_valid = 1'b0;
    push_expect(32'h8000, 162);
    base_addr = 32'h8000; num_groups = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(beats_seen >= 10 && rready) && w < 2000) begin @(posedge clk); #1; w++; end
    check("reset_reached_data", DW'(rready), DW'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", DW'(busy), DW'(1'b0));
    check("arst_rready", DW'(rready), DW'(1'b0));
    check("arst_valid_out", DW'(valid_out), DW'(1'b0));
    check("arst_data_out", data_out, {DW{1'b0}});
    check("arst_araddr", DW'(araddr), DW'(32'h0));
    check("arst_arlen_arvalid", DW'({arlen, arvalid, done, err}), DW'(11'h0));
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    exp_ar_q.delete();
    rstn = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", DW'(busy), DW'(1'b0));
    run_job(32'h7000, 1, 0, 1, 1'b0, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
